pipelined_cla_addsub: RTL

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. Operands are split into 4-bit lookahead groups, and groups are bundled into pipeline stages. Carry ripples between stages through registers, and lookahead is used within each stage. A valid/ready handshake gives one-op-per-cycle throughput with back-pressure. The block returns the sum or difference plus carry, overflow and zero flags to the ALU result mux.

---
 rtl/pipelined_cla_addsub_pkg.sv | 29 ++
 rtl/pipelined_cla_addsub_if.sv | 25 ++
 rtl/cla_group4.sv | 28 ++
 rtl/pipelined_cla_addsub.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// ALU op encodings, lookahead group width and op decode helpers.
package pipelined_cla_addsub_pkg;

   localparam int GROUP_W = 4;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_ADDC = 2'b10,
      ALU_SUBB = 2'b11
   } alu_op_e;

   function automatic logic op_inverts_y(input logic [1:0] op);
      return (op == ALU_SUB) || (op == ALU_SUBB);
   endfunction

   // Carry into bit 0: fixed for ADD/SUB, caller-supplied for ADDC/SUBB.
   function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
      logic c0;
      case (op)
         ALU_ADD: c0 = 1'b0;
         ALU_SUB: c0 = 1'b1;
         default: c0 = cin;
      endcase
      return c0;
   endfunction

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Handshake/data bundle between the ALU issue logic and the pipelined adder.
interface pipelined_cla_addsub_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_s;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_op, in_x, in_y, in_cin, out_ready,
      input  in_ready, out_valid, out_s, out_cout, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_op, in_x, in_y, in_cin, out_ready,
      output in_ready, out_valid, out_s, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: full lookahead for the internal carries,
// plus group generate/propagate for the second-level lookahead.
module cla_group4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] s,
   output logic       g,
   output logic       p
);
   logic [3:0] gen;
   logic [3:0] prop;
   logic [3:0] c;

   assign gen  = x & y;
   assign prop = x ^ y;

   assign c[0] = cin;
   assign c[1] = gen[0] | (prop[0] & cin);
   assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
   assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
               | (prop[2] & prop[1] & prop[0] & cin);

   assign s = prop ^ c;
   assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]);
   assign p = &prop;
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves GPS 4-bit
// groups with two-level lookahead; the carry ripples stage to stage in registers.
module pipelined_cla_addsub
   import pipelined_cla_addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GPS   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   pipelined_cla_addsub_if.slave  bus
);
   localparam int SW     = GROUP_W * GPS;
   localparam bit CFG_OK = (GPS > 0) && (WIDTH > 0) && ((WIDTH % SW) == 0);
   localparam int STAGES = CFG_OK ? (WIDTH / SW) : 1;
   localparam int LAST   = STAGES - 1;

   if (!CFG_OK) begin : g_bad_cfg
      $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of 4*GPS");
   end

   logic             adv;
   logic [WIDTH-1:0] y_eff;
   logic             c0;
   logic             ovf_reg;
   logic             zero_reg;
   logic [WIDTH-1:0] s_last_next;
   logic             msb_cin;

   // The whole pipeline moves as one unit; bubbles are never squeezed out.
   assign adv          = ~g_stage[LAST].v_reg | bus.out_ready;
   assign bus.in_ready = adv;
   assign y_eff        = op_inverts_y(bus.in_op) ? ~bus.in_y : bus.in_y;
   assign c0           = op_carry_in(bus.in_op, bus.in_cin);

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO  = gi * SW;
      localparam int REM = WIDTH - LO;

      logic                v_in;
      logic                c_in;
      logic [REM-1:0]      x_in;
      logic [REM-1:0]      y_in;
      logic [GPS:0]        c_grp;
      logic [GPS-1:0]      grp_g;
      logic [GPS-1:0]      grp_p;
      logic [SW-1:0]       s_slice;
      logic [LO+SW-1:0]    s_next;
      logic                v_reg;
      logic                c_reg;
      logic [LO+SW-1:0]    s_reg;

      if (gi == 0) begin : g_src
         assign v_in   = bus.in_valid;
         assign c_in   = c0;
         assign x_in   = bus.in_x;
         assign y_in   = y_eff;
         assign s_next = s_slice;
      end else begin : g_src
         assign v_in   = g_stage[gi-1].v_reg;
         assign c_in   = g_stage[gi-1].c_reg;
         assign x_in   = g_stage[gi-1].g_fwd.x_reg;
         assign y_in   = g_stage[gi-1].g_fwd.y_reg;
         assign s_next = {s_slice, g_stage[gi-1].s_reg};
      end

      for (genvar gj = 0; gj < GPS; gj++) begin : g_grp
         cla_group4 u_grp (
            .x   (x_in[gj*GROUP_W +: GROUP_W]),
            .y   (y_in[gj*GROUP_W +: GROUP_W]),
            .cin (c_grp[gj]),
            .s   (s_slice[gj*GROUP_W +: GROUP_W]),
            .g   (grp_g[gj]),
            .p   (grp_p[gj])
         );
      end

      // Second level: every group carry as a flat sum of products of G/P and c_in.
      always_comb begin : lookahead
         logic acc;
         logic term;
         c_grp = '0;
         acc   = 1'b0;
         term  = 1'b0;
         for (int j = 0; j <= GPS; j++) begin
            term = c_in;
            for (int m = 0; m < j; m++) term &= grp_p[m];
            acc = term;
            for (int i = 0; i < j; i++) begin
               term = grp_g[i];
               for (int m = i + 1; m < j; m++) term &= grp_p[m];
               acc |= term;
            end
            c_grp[j] = acc;
         end
      end

      // Operand bits above this stage's slice travel along for later stages.
      if (gi < LAST) begin : g_fwd
         logic [REM-SW-1:0] x_reg;
         logic [REM-SW-1:0] y_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               x_reg <= '0;
               y_reg <= '0;
            end else if (adv) begin
               x_reg <= x_in[REM-1:SW];
               y_reg <= y_in[REM-1:SW];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_reg <= 1'b0;
            c_reg <= 1'b0;
            s_reg <= '0;
         end else if (adv) begin
            v_reg <= v_in;
            c_reg <= c_grp[GPS];
            s_reg <= s_next;
         end
      end
   end

   // Carry into the MSB recovered from its sum bit: s = x ^ y' ^ c.
   assign s_last_next = g_stage[LAST].s_next;
   assign msb_cin     = s_last_next[WIDTH-1] ^ g_stage[LAST].x_in[SW-1]
                      ^ g_stage[LAST].y_in[SW-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else if (adv) begin
         ovf_reg  <= msb_cin ^ g_stage[LAST].c_grp[GPS];
         zero_reg <= ~|s_last_next;
      end
   end

   assign bus.out_valid = g_stage[LAST].v_reg;
   assign bus.out_s     = g_stage[LAST].s_reg;
   assign bus.out_cout  = g_stage[LAST].c_reg;
   assign bus.out_ovf   = ovf_reg;
   assign bus.out_zero  = zero_reg;
endmodule
